mem_ctrl: RTL and testbench
===========================

MEM_CTRL -- requirements
Module: mem_ctrl

Interface
REQ-001 SHALL have port clk  in  1  rising-edge clock.
REQ-002 SHALL have port rst  in  1  reset, synchronous, active-high.
REQ-003 SHALL have port mem_r_en_i  in  1  MEM-stage read request.
REQ-004 SHALL have port mem_w_en_i  in  1  MEM-stage write request.
REQ-005 SHALL have port mem_addr_i  in  32  MEM-stage byte address.
REQ-006 SHALL have port mem_w_data_i  in  32  store data, with the stored byte or half in the low bits.
REQ-007 SHALL have port mem_mask_i  in  2  write size: 01 byte, 10 half, 11 word, 00 none.
REQ-008 SHALL have port if_r_en_i  in  1  fetch read request.
REQ-009 SHALL have port if_addr_i  in  32  fetch byte address.
REQ-010 SHALL have port busy_o  out  1  controller not in IDLE; shared by both ports.
REQ-011 SHALL have port mem_done_o  out  1  one-cycle pulse marking completion of a MEM request.
REQ-012 SHALL have port if_done_o  out  1  one-cycle pulse marking completion of an IF request.
REQ-013 SHALL have port rd_data_o  out  32  last assembled read word.
REQ-014 SHALL have port ram_a_o  out  32  external RAM byte address.
REQ-015 SHALL have port ram_dout_o  out  8  byte written to RAM.
REQ-016 SHALL have port ram_din_i  in  8  byte read from RAM, valid one cycle after its address.
REQ-017 SHALL have port ram_wr_o  out  1  1 = write strobe for the current cycle.

Function
REQ-018 SHALL implement FSM states IDLE, READ, WRITE, DONE.
REQ-019 SHALL accept a request only in IDLE, latching the port, address, data and size; requests in other states are ignored, and the requester retries once busy_o is low.
REQ-020 SHALL give MEM priority over IF when both request in the same IDLE cycle.
REQ-021 SHALL give mem_w_en_i priority over mem_r_en_i when both are asserted.
REQ-022 SHALL, for a read, force base = {addr[31:2],2'b00} and enter READ with cnt=0.
REQ-023 SHALL, in READ, drive ram_a_o=base+cnt with ram_wr_o=0, capture ram_din_i into byte lane cnt-1 when cnt>=1, and increment cnt, leaving READ after cnt=4.
REQ-024 SHALL assemble the read word little-endian: the byte at base lands in bits [7:0].
REQ-025 SHALL, for a write with a nonzero mask, use n=1/2/4 bytes and the address unaligned as given.
REQ-026 SHALL, in WRITE, drive ram_a_o=addr+cnt, ram_dout_o=w_data byte cnt and ram_wr_o=1 for cnt=0..n-1, then go to DONE.
REQ-027 SHALL send a write with mask 00 straight from IDLE to DONE with no RAM strobe.
REQ-028 SHALL, in DONE, pulse the done output of the served port for exactly one cycle, update rd_data_o in that same cycle for reads, and return to IDLE.
REQ-029 SHALL give read latency as: acceptance edge, then 5 READ cycles, then done in cycle 6.
REQ-030 SHALL give write latency as n WRITE cycles, then done in cycle n+1.
REQ-031 SHALL drive ram_wr_o=0 and ram_dout_o=0 in every state except WRITE.
REQ-032 SHALL drive busy_o=1 in READ, WRITE and DONE, and 0 in IDLE.
REQ-033 SHALL hold rd_data_o between reads; writes SHALL NOT alter it.
REQ-034 SHALL compute all address arithmetic modulo 2^32, so that wrap past 0xFFFFFFFF reaches 0.

Reset
REQ-035 SHALL, on rst, go to IDLE with cnt=0 and drive busy_o=0, mem_done_o=0, if_done_o=0, rd_data_o=0, ram_a_o=0, ram_dout_o=0 and ram_wr_o=0.
REQ-036 SHALL, on rst during READ or WRITE, abort the access with no done pulse and no further ram_wr_o; bytes already written stay in RAM.

Structure
REQ-037 SHALL place the state encodings and the mask constants (01/10/11) in the shared defines package, so that the MEM stage and this block use one definition.
REQ-038 SHALL be a single module with no sub-module.

Verification
REQ-039 SHALL cover a MEM word read at 0x1006 with RAM[0x1004..7]=11,22,33,44 -> ram_a_o sequence 0x1004..0x1007, mem_done_o in cycle 6, rd_data_o=0x44332211.
REQ-040 SHALL cover a MEM byte write at 0x2003 with data 0x000000AB, mask 01 -> one cycle with ram_wr_o=1, ram_a_o=0x2003, ram_dout_o=0xAB, then mem_done_o.
REQ-041 SHALL cover simultaneous IF read 0x0 and MEM word write 0x10 with data 0xDEADBEEF -> bytes EF,BE,AD,DE written at 0x10..0x13, mem_done_o and no if_done_o, after which an IF retry completes.
REQ-042 SHALL cover rst asserted in the 3rd WRITE cycle of a word store -> IDLE next cycle, ram_wr_o=0, no done pulse, busy_o=0.
REQ-043 SHALL cover a write with mask 00 -> no strobe and mem_done_o in the cycle after acceptance.
REQ-044 SHALL cover an IF read at 0xFFFFFFFC -> addresses 0xFFFFFFFC..0xFFFFFFFF, with cnt=4 wrapping ram_a_o to 0x0 (harmless), and if_done_o.

Source files
------------

// File: rtl/mem_ctrl_pkg.sv
// Shared definitions for the memory controller and the MEM stage that drives it.
// Holds the controller state encoding, the store-size mask constants and a
// helper that turns a mask into a byte count.
package mem_ctrl_pkg;

    typedef enum logic [1:0] {
        StIdle  = 2'b00,
        StRead  = 2'b01,
        StWrite = 2'b10,
        StDone  = 2'b11
    } state_e;

    localparam logic [1:0] MaskNone = 2'b00;
    localparam logic [1:0] MaskByte = 2'b01;
    localparam logic [1:0] MaskHalf = 2'b10;
    localparam logic [1:0] MaskWord = 2'b11;

    function automatic logic [2:0] mask_bytes(input logic [1:0] mask);
        logic [2:0] n;
        case (mask)
            MaskByte: n = 3'd1;
            MaskHalf: n = 3'd2;
            MaskWord: n = 3'd4;
            default:  n = 3'd0;
        endcase
        return n;
    endfunction

endpackage

// File: rtl/mem_ctrl.sv
// Byte-serial memory controller shared by the fetch (IF) and MEM ports.
// One request at a time is accepted in IDLE (MEM before IF, write before read),
// then bytes are moved over an 8-bit RAM interface.
// Ports:
//   clk, rst            - clock, synchronous active-high reset
//   mem_r_en_i/mem_w_en_i, mem_addr_i, mem_w_data_i, mem_mask_i - MEM-stage request
//   if_r_en_i, if_addr_i - fetch read request
//   busy_o              - high whenever not IDLE
//   mem_done_o, if_done_o - one-cycle completion pulse for the served port
//   rd_data_o           - last assembled read word (little-endian)
//   ram_a_o, ram_dout_o, ram_wr_o, ram_din_i - external byte RAM
module mem_ctrl
    import mem_ctrl_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_r_en_i,
    input  logic        mem_w_en_i,
    input  logic [31:0] mem_addr_i,
    input  logic [31:0] mem_w_data_i,
    input  logic [1:0]  mem_mask_i,
    input  logic        if_r_en_i,
    input  logic [31:0] if_addr_i,
    output logic        busy_o,
    output logic        mem_done_o,
    output logic        if_done_o,
    output logic [31:0] rd_data_o,
    output logic [31:0] ram_a_o,
    output logic [7:0]  ram_dout_o,
    input  logic [7:0]  ram_din_i,
    output logic        ram_wr_o
);

    state_e      state_q, state_d;
    logic [2:0]  cnt_q, cnt_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [2:0]  nbytes_q, nbytes_d;
    logic        port_if_q, port_if_d;
    logic [23:0] rbuf_q, rbuf_d;
    logic [31:0] rd_data_q, rd_data_d;
    logic [31:0] wshift;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (mem_w_en_i) begin
                    state_d = (mem_mask_i == MaskNone) ? StDone : StWrite;
                end else if (mem_r_en_i || if_r_en_i) begin
                    state_d = StRead;
                end
            end
            StRead:  if (cnt_q == 3'd4) state_d = StDone;
            StWrite: if (cnt_q == nbytes_q - 3'd1) state_d = StDone;
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Datapath next-state: request latch, byte counter and read assembly
    always_comb begin
        cnt_d     = cnt_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        nbytes_d  = nbytes_q;
        port_if_d = port_if_q;
        rbuf_d    = rbuf_q;
        rd_data_d = rd_data_q;
        unique case (state_q)
            StIdle: begin
                cnt_d = 3'd0;
                if (mem_w_en_i) begin
                    port_if_d = 1'b0;
                    addr_d    = mem_addr_i;
                    wdata_d   = mem_w_data_i;
                    nbytes_d  = mask_bytes(mem_mask_i);
                end else if (mem_r_en_i) begin
                    port_if_d = 1'b0;
                    addr_d    = {mem_addr_i[31:2], 2'b00};
                end else if (if_r_en_i) begin
                    port_if_d = 1'b1;
                    addr_d    = {if_addr_i[31:2], 2'b00};
                end
            end
            StRead: begin
                cnt_d = cnt_q + 3'd1;
                // RAM data lags its address by one cycle, so lane cnt-1 arrives now.
                // The last lane goes straight into rd_data so it is visible in DONE.
                case (cnt_q)
                    3'd1:    rbuf_d[7:0]   = ram_din_i;
                    3'd2:    rbuf_d[15:8]  = ram_din_i;
                    3'd3:    rbuf_d[23:16] = ram_din_i;
                    3'd4:    rd_data_d     = {ram_din_i, rbuf_q};
                    default: ;
                endcase
            end
            StWrite: cnt_d = cnt_q + 3'd1;
            StDone:  cnt_d = 3'd0;
            default: cnt_d = 3'd0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q     <= 3'd0;
            addr_q    <= 32'd0;
            wdata_q   <= 32'd0;
            nbytes_q  <= 3'd0;
            port_if_q <= 1'b0;
            rbuf_q    <= 24'd0;
            rd_data_q <= 32'd0;
        end else begin
            cnt_q     <= cnt_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            nbytes_q  <= nbytes_d;
            port_if_q <= port_if_d;
            rbuf_q    <= rbuf_d;
            rd_data_q <= rd_data_d;
        end
    end

    // Outputs, decoded from registered state only
    always_comb begin
        busy_o     = (state_q != StIdle);
        mem_done_o = (state_q == StDone) && !port_if_q;
        if_done_o  = (state_q == StDone) && port_if_q;
        ram_a_o    = 32'd0;
        ram_dout_o = 8'd0;
        ram_wr_o   = 1'b0;
        wshift     = wdata_q >> {cnt_q[1:0], 3'b000};
        unique case (state_q)
            StRead: ram_a_o = addr_q + {29'd0, cnt_q};
            StWrite: begin
                ram_a_o    = addr_q + {29'd0, cnt_q};
                ram_dout_o = wshift[7:0];
                ram_wr_o   = 1'b1;
            end
            default: ;
        endcase
    end

    assign rd_data_o = rd_data_q;

endmodule

// File: tb/tb_mem_ctrl.sv
module tb_mem_ctrl;

    logic        clk, rst;
    logic        mem_r_en_i, mem_w_en_i, if_r_en_i;
    logic [31:0] mem_addr_i, mem_w_data_i, if_addr_i;
    logic [1:0]  mem_mask_i;
    logic        busy_o, mem_done_o, if_done_o, ram_wr_o;
    logic [31:0] rd_data_o, ram_a_o;
    logic [7:0]  ram_dout_o, ram_din_i;

    mem_ctrl dut (
        .clk         (clk),
        .rst         (rst),
        .mem_r_en_i  (mem_r_en_i),
        .mem_w_en_i  (mem_w_en_i),
        .mem_addr_i  (mem_addr_i),
        .mem_w_data_i(mem_w_data_i),
        .mem_mask_i  (mem_mask_i),
        .if_r_en_i   (if_r_en_i),
        .if_addr_i   (if_addr_i),
        .busy_o      (busy_o),
        .mem_done_o  (mem_done_o),
        .if_done_o   (if_done_o),
        .rd_data_o   (rd_data_o),
        .ram_a_o     (ram_a_o),
        .ram_dout_o  (ram_dout_o),
        .ram_din_i   (ram_din_i),
        .ram_wr_o    (ram_wr_o)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct packed {
        logic [31:0] a;
        logic [7:0]  d;
    } wr_t;

    typedef struct packed {
        logic        is_if;
        logic [31:0] rd;
    } sb_t;

    typedef struct {
        logic        mr, mw, ir;
        logic [31:0] maddr, iaddr, wdata;
        logic [1:0]  mask;
        int          lat;
        logic [31:0] rd;
    } vec_t;

    wr_t         wq[$];
    logic [31:0] rq[$];
    sb_t         sbq[$];
    int          n_tests = 0;
    int          n_fail = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Byte RAM, low 16 address bits; data appears one cycle after its address.
    logic [7:0] ram [0:65535];
    logic       preload;

    always @(posedge clk) begin
        if (preload) begin
            ram[16'h1004] <= 8'h11; ram[16'h1005] <= 8'h22;
            ram[16'h1006] <= 8'h33; ram[16'h1007] <= 8'h44;
            ram[16'h2000] <= 8'h01; ram[16'h2001] <= 8'h02; ram[16'h2002] <= 8'h03;
            ram[16'hFFFC] <= 8'hA1; ram[16'hFFFD] <= 8'hB2;
            ram[16'hFFFE] <= 8'hC3; ram[16'hFFFF] <= 8'hD4;
            ram[16'h0000] <= 8'h10; ram[16'h0001] <= 8'h20;
            ram[16'h0002] <= 8'h9A; ram[16'h0003] <= 8'hBC;
        end else begin
            ram_din_i <= ram[ram_a_o[15:0]];
            if (ram_wr_o) ram[ram_a_o[15:0]] <= ram_dout_o;
        end
    end

    // Scoreboard monitors: done pulses, write strobes and read addresses
    always @(negedge clk) begin
        if (mem_done_o || if_done_o) begin
            if (sbq.size() == 0) begin
                check("unexpected_done", {31'd0, mem_done_o | if_done_o}, 32'd0);
            end else begin
                sb_t e;
                e = sbq.pop_front();
                check("done_is_if", {31'd0, if_done_o}, {31'd0, e.is_if});
                check("done_is_mem", {31'd0, mem_done_o}, {31'd0, ~e.is_if});
                check("rd_data", rd_data_o, e.rd);
            end
        end
        if (ram_wr_o) begin
            if (wq.size() == 0) begin
                check("unexpected_wr", {31'd0, ram_wr_o}, 32'd0);
            end else begin
                wr_t w;
                w = wq.pop_front();
                check("wr_addr", ram_a_o, w.a);
                check("wr_data", {24'd0, ram_dout_o}, {24'd0, w.d});
            end
        end else if (busy_o && !mem_done_o && !if_done_o) begin
            if (rq.size() == 0) begin
                check("unexpected_rd", ram_a_o, 32'hFFFF_FFFF);
            end else begin
                check("rd_addr", ram_a_o, rq.pop_front());
            end
        end else begin
            check("dout_idle", {24'd0, ram_dout_o}, 32'd0);
        end
    end

    task automatic clear_inputs();
        mem_r_en_i = 1'b0; mem_w_en_i = 1'b0; if_r_en_i = 1'b0;
        mem_addr_i = 32'd0; mem_w_data_i = 32'd0; mem_mask_i = 2'b00; if_addr_i = 32'd0;
    endtask

    // Called at a negedge with the DUT idle; returns at a negedge with the DUT idle.
    task automatic do_req(input vec_t v);
        int          lat;
        int          n;
        logic [31:0] base;
        sb_t         e;
        e.is_if = !(v.mr || v.mw);
        e.rd    = v.rd;
        sbq.push_back(e);
        if (v.mw) begin
            n = (v.mask == 2'b01) ? 1 : (v.mask == 2'b10) ? 2 : (v.mask == 2'b11) ? 4 : 0;
            for (int i = 0; i < n; i++) wq.push_back('{a: v.maddr + 32'(i), d: v.wdata[8*i +: 8]});
        end else begin
            base = v.mr ? {v.maddr[31:2], 2'b00} : {v.iaddr[31:2], 2'b00};
            for (int k = 0; k < 5; k++) rq.push_back(base + 32'(k));
        end
        mem_r_en_i = v.mr; mem_w_en_i = v.mw; if_r_en_i = v.ir;
        mem_addr_i = v.maddr; if_addr_i = v.iaddr; mem_w_data_i = v.wdata; mem_mask_i = v.mask;
        @(negedge clk);
        clear_inputs();
        lat = 1;
        while (!(mem_done_o || if_done_o) && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        check("latency", 32'(lat), 32'(v.lat));
        @(negedge clk);
        check("idle_after_done", {31'd0, busy_o}, 32'd0);
    endtask

    vec_t vecs[12];

    initial begin
        int lat;
        //          mr    mw    ir    maddr          iaddr          wdata          mask   lat rd
        vecs[0]  = '{1'b1, 1'b0, 1'b0, 32'h0000_1006, 32'h0,        32'h0,         2'b00, 6, 32'h4433_2211};
        vecs[1]  = '{1'b0, 1'b1, 1'b0, 32'h0000_2003, 32'h0,        32'h0000_00AB, 2'b01, 2, 32'h4433_2211};
        vecs[2]  = '{1'b0, 1'b1, 1'b0, 32'h0000_3001, 32'h0,        32'h1234_CAFE, 2'b10, 3, 32'h4433_2211};
        vecs[3]  = '{1'b0, 1'b1, 1'b0, 32'h0000_4000, 32'h0,        32'h5555_5555, 2'b00, 1, 32'h4433_2211};
        vecs[4]  = '{1'b0, 1'b0, 1'b1, 32'h0,         32'hFFFF_FFFC, 32'h0,        2'b00, 6, 32'hD4C3_B2A1};
        vecs[5]  = '{1'b1, 1'b0, 1'b0, 32'h0000_2001, 32'h0,        32'h0,         2'b00, 6, 32'hAB03_0201};
        vecs[6]  = '{1'b0, 1'b1, 1'b0, 32'hFFFF_FFFE, 32'h0,        32'h5566_7788, 2'b11, 5, 32'hAB03_0201};
        vecs[7]  = '{1'b0, 1'b0, 1'b1, 32'h0,         32'h0000_0003, 32'h0,        2'b00, 6, 32'hBC9A_5566};
        vecs[8]  = '{1'b1, 1'b1, 1'b0, 32'h0000_0060, 32'h0,        32'h0BAD_F00D, 2'b01, 2, 32'hBC9A_5566};
        vecs[9]  = '{1'b0, 1'b1, 1'b1, 32'h0000_0010, 32'h0,        32'hDEAD_BEEF, 2'b11, 5, 32'hBC9A_5566};
        vecs[10] = '{1'b0, 1'b0, 1'b1, 32'h0,         32'h0,        32'h0,         2'b00, 6, 32'hBC9A_5566};
        vecs[11] = '{1'b1, 1'b0, 1'b0, 32'h0000_0012, 32'h0,        32'h0,         2'b00, 6, 32'hDEAD_BEEF};

        rst = 1'b1;
        preload = 1'b1;
        clear_inputs();
        repeat (3) @(negedge clk);
        check("rst_busy", {31'd0, busy_o}, 32'd0);
        check("rst_mem_done", {31'd0, mem_done_o}, 32'd0);
        check("rst_if_done", {31'd0, if_done_o}, 32'd0);
        check("rst_rd_data", rd_data_o, 32'd0);
        check("rst_ram_a", ram_a_o, 32'd0);
        check("rst_ram_dout", {24'd0, ram_dout_o}, 32'd0);
        check("rst_ram_wr", {31'd0, ram_wr_o}, 32'd0);
        preload = 1'b0;
        rst = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 12; i++) do_req(vecs[i]);

        // Reset during the third byte of a word store: three strobes, then abort.
        wq.push_back('{a: 32'h80, d: 8'h44});
        wq.push_back('{a: 32'h81, d: 8'h33});
        wq.push_back('{a: 32'h82, d: 8'h22});
        mem_w_en_i = 1'b1; mem_addr_i = 32'h80; mem_w_data_i = 32'h1122_3344; mem_mask_i = 2'b11;
        @(negedge clk);
        clear_inputs();
        repeat (2) @(negedge clk);
        check("wr_before_rst", {31'd0, ram_wr_o}, 32'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort_busy", {31'd0, busy_o}, 32'd0);
        check("abort_ram_wr", {31'd0, ram_wr_o}, 32'd0);
        check("abort_done", {30'd0, mem_done_o, if_done_o}, 32'd0);
        check("abort_rd_data", rd_data_o, 32'd0);
        repeat (3) @(negedge clk);
        check("abort_still_idle", {31'd0, busy_o}, 32'd0);

        // A store request raised mid-read must be ignored.
        sbq.push_back('{is_if: 1'b0, rd: 32'h4433_2211});
        for (int k = 0; k < 5; k++) rq.push_back(32'h1004 + 32'(k));
        mem_r_en_i = 1'b1; mem_addr_i = 32'h1004;
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
            clear_inputs();
            if (lat == 2) begin
                mem_w_en_i = 1'b1; mem_addr_i = 32'h90; mem_mask_i = 2'b11;
                mem_w_data_i = 32'hCCCC_CCCC;
            end
        end while (!(mem_done_o || if_done_o) && lat < 20);
        clear_inputs();
        check("busy_ignore_latency", 32'(lat), 32'd6);
        @(negedge clk);
        check("busy_ignore_idle", {31'd0, busy_o}, 32'd0);

        check("sb_empty", 32'(sbq.size()), 32'd0);
        check("wq_empty", 32'(wq.size()), 32'd0);
        check("rq_empty", 32'(rq.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
